// File: rtl/snake_step_engine.sv
// Snake motion core: heading, head position, body history and length, stepping once every STEP_DIV clocks.
// Optional macro SNAKE_WALL_KILL_EN: leaving the grid is fatal instead of wrapping to the opposite edge.
module snake_step_engine #(
    parameter int GRID_W   = 32,
    parameter int GRID_H   = 24,
    parameter int COORD_W  = 5,
    parameter int MAX_LEN  = 16,
    parameter int STEP_DIV = 6250000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [1:0]                 move_direction,
    input  logic                       pause,
    input  logic                       grow,
    input  logic [COORD_W-1:0]         qx,
    input  logic [COORD_W-1:0]         qy,
    output logic [COORD_W-1:0]         head_x,
    output logic [COORD_W-1:0]         head_y,
    output logic [1:0]                 heading,
    output logic [$clog2(MAX_LEN):0]   length,
    output logic                       step_pulse,
    output logic                       q_hit,
    output logic                       dead
);

    localparam int LEN_W = $clog2(MAX_LEN) + 1;
    localparam int DIV_W = $clog2(STEP_DIV);
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(STEP_DIV - 1);
    localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(GRID_W - 1);
    localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(GRID_H - 1);

`ifdef SNAKE_WALL_KILL_EN
    localparam logic WALL_KILL = 1'b1;
`else
    localparam logic WALL_KILL = 1'b0;
`endif

    typedef enum logic [1:0] {RUN, PAUSED, DEAD} state_t;

    state_t             state;
    logic [COORD_W-1:0] seg_x [MAX_LEN];
    logic [COORD_W-1:0] seg_y [MAX_LEN];
    logic [DIV_W-1:0]   div_cnt;
    logic               grow_latch;

    logic               running;
    logic               terminal;
    logic               growing;
    logic               off_grid;
    logic               body_hit;
    logic               step_hit;
    logic               query_hit;
    logic [1:0]         next_heading;
    logic [COORD_W-1:0] next_x;
    logic [COORD_W-1:0] next_y;

    assign head_x = seg_x[0];
    assign head_y = seg_y[0];

    // Pause is a level: the divider resumes in the very cycle pause drops, so the remaining count is exact.
    always_comb begin
        running      = (state != DEAD) && !pause;
        terminal     = running && (div_cnt == DIV_LAST);
        growing      = (grow_latch | grow) && (length < LEN_W'(MAX_LEN));
        next_heading = (move_direction == (heading ^ 2'd2)) ? heading : move_direction;
        next_x       = seg_x[0];
        next_y       = seg_y[0];
        off_grid     = 1'b0;
        case (next_heading)
            2'd0: begin
                if (seg_x[0] == '0) begin
                    next_x   = X_LAST;
                    off_grid = 1'b1;
                end else begin
                    next_x = seg_x[0] - COORD_W'(1);
                end
            end
            2'd1: begin
                if (seg_y[0] == '0) begin
                    next_y   = Y_LAST;
                    off_grid = 1'b1;
                end else begin
                    next_y = seg_y[0] - COORD_W'(1);
                end
            end
            2'd2: begin
                if (seg_x[0] == X_LAST) begin
                    next_x   = '0;
                    off_grid = 1'b1;
                end else begin
                    next_x = seg_x[0] + COORD_W'(1);
                end
            end
            default: begin
                if (seg_y[0] == Y_LAST) begin
                    next_y   = '0;
                    off_grid = 1'b1;
                end else begin
                    next_y = seg_y[0] + COORD_W'(1);
                end
            end
        endcase
    end

    // The tail vacates on a non-growing step, so it cannot be hit by the new head.
    always_comb begin
        body_hit  = 1'b0;
        query_hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (LEN_W'(i) < length) begin
                if (seg_x[i] == qx && seg_y[i] == qy) begin
                    query_hit = 1'b1;
                end
                if (seg_x[i] == next_x && seg_y[i] == next_y &&
                    (growing || LEN_W'(i) != length - LEN_W'(1))) begin
                    body_hit = 1'b1;
                end
            end
        end
        step_hit = body_hit | (WALL_KILL & off_grid);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            div_cnt    <= '0;
            grow_latch <= 1'b0;
            heading    <= 2'd2;
            length     <= LEN_W'(3);
            step_pulse <= 1'b0;
            q_hit      <= 1'b0;
            dead       <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= (i < 3) ? COORD_W'(GRID_W / 2 - i) : COORD_W'(GRID_W / 2);
                seg_y[i] <= COORD_W'(GRID_H / 2);
            end
        end else begin
            q_hit      <= query_hit;
            step_pulse <= terminal;

            if (terminal) begin
                grow_latch <= 1'b0;
            end else if (grow) begin
                grow_latch <= 1'b1;
            end

            if (terminal) begin
                div_cnt <= '0;
            end else if (running) begin
                div_cnt <= div_cnt + DIV_W'(1);
            end

            if (terminal && step_hit) begin
                state <= DEAD;
                dead  <= 1'b1;
            end else begin
                case (state)
                    RUN:     if (pause)  state <= PAUSED;
                    PAUSED:  if (!pause) state <= RUN;
                    default: state <= DEAD;
                endcase
            end

            if (terminal && !step_hit) begin
                heading <= next_heading;
                for (int i = 1; i < MAX_LEN; i++) begin
                    seg_x[i] <= seg_x[i-1];
                    seg_y[i] <= seg_y[i-1];
                end
                seg_x[0] <= next_x;
                seg_y[0] <= next_y;
                if (growing) begin
                    length <= length + LEN_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_snake_step_engine.sv
// Bench for snake_step_engine on an 8x8 grid: directed scenarios plus random traffic against a queue-based snake model.
// Honours SNAKE_WALL_KILL_EN so the same bench covers both edge behaviours.
module tb_snake_step_engine;

    localparam int GW = 8;
    localparam int GH = 8;
    localparam int CW = 3;
    localparam int ML = 8;
    localparam int SD = 4;
    localparam int LW = $clog2(ML) + 1;

`ifdef SNAKE_WALL_KILL_EN
    localparam bit WALL_KILL = 1'b1;
`else
    localparam bit WALL_KILL = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    move_direction = 2'd2;
    logic          pause = 1'b0;
    logic          grow = 1'b0;
    logic [CW-1:0] qx = '0;
    logic [CW-1:0] qy = '0;
    logic [CW-1:0] head_x;
    logic [CW-1:0] head_y;
    logic [1:0]    heading;
    logic [LW-1:0] length;
    logic          step_pulse;
    logic          q_hit;
    logic          dead;

    int n_checks = 0;
    int n_fail   = 0;

    snake_step_engine #(
        .GRID_W(GW), .GRID_H(GH), .COORD_W(CW), .MAX_LEN(ML), .STEP_DIV(SD)
    ) dut (
        .clk(clk), .reset(reset), .move_direction(move_direction), .pause(pause), .grow(grow),
        .qx(qx), .qy(qy), .head_x(head_x), .head_y(head_y), .heading(heading), .length(length),
        .step_pulse(step_pulse), .q_hit(q_hit), .dead(dead)
    );

    always #5 clk = ~clk;

    // Reference snake: body as coordinate queues with the head at index 0.
    int bx[$];
    int by[$];
    int m_heading;
    int m_div;
    bit m_glatch;
    bit m_dead;
    bit m_pulse;
    bit m_qhit;

    function automatic bit model_occupied(int x, int y, int n);
        for (int i = 0; i < n; i++) begin
            if (bx[i] == x && by[i] == y) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic void model_reset();
        bx.delete();
        by.delete();
        for (int i = 0; i < 3; i++) begin
            bx.push_back(GW / 2 - i);
            by.push_back(GH / 2);
        end
        m_heading = 2;
        m_div     = 0;
        m_glatch  = 0;
        m_dead    = 0;
        m_pulse   = 0;
        m_qhit    = 0;
    endfunction

    function automatic void model_step(bit g);
        int h, dx, dy, nx, ny, n;
        bit off, growing;
        h  = (int'(move_direction) == (m_heading ^ 2)) ? m_heading : int'(move_direction);
        dx = (h == 0) ? -1 : (h == 2) ? 1 : 0;
        dy = (h == 1) ? -1 : (h == 3) ? 1 : 0;
        nx = bx[0] + dx;
        ny = by[0] + dy;
        off = (nx < 0) || (nx >= GW) || (ny < 0) || (ny >= GH);
        nx = (nx + GW) % GW;
        ny = (ny + GH) % GH;
        growing = g && (bx.size() < ML);
        n = growing ? bx.size() : bx.size() - 1;
        if ((WALL_KILL && off) || model_occupied(nx, ny, n)) begin
            m_dead = 1;
        end else begin
            m_heading = h;
            bx.push_front(nx);
            by.push_front(ny);
            if (!growing) begin
                void'(bx.pop_back());
                void'(by.pop_back());
            end
        end
    endfunction

    // Advances the model across one clock edge using the inputs currently driven.
    function automatic void model_clock();
        if (reset) begin
            model_reset();
            return;
        end
        m_qhit  = model_occupied(int'(qx), int'(qy), bx.size());
        m_pulse = 0;
        if (!m_dead && !pause && m_div == SD - 1) begin
            m_div   = 0;
            m_pulse = 1;
            model_step(m_glatch | grow);
            m_glatch = 0;
        end else begin
            if (!m_dead && !pause) m_div++;
            if (grow) m_glatch = 1;
        end
    endfunction

    function automatic logic [14:0] exp_vec();
        return {CW'(bx[0]), CW'(by[0]), 2'(m_heading), LW'(bx.size()), m_pulse, m_qhit, m_dead};
    endfunction

    function automatic logic [14:0] obs_vec();
        return {head_x, head_y, heading, length, step_pulse, q_hit, dead};
    endfunction

    task automatic cycle();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        qx = 3'd4;
        qy = 3'd4;
        grow = 1'b1;
        do_reset();
        grow = 1'b0;
        n_checks++;
        if ({head_x, head_y, heading, length, step_pulse, q_hit, dead} !== {3'd4, 3'd4, 2'd2, 4'd3, 3'b000}) begin
            n_fail++;
            $display("[TB] FAIL reset_values: got %h expected %h", obs_vec(), {3'd4, 3'd4, 2'd2, 4'd3, 3'b000});
        end
        cycle();
        n_checks++;
        if (q_hit !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_query_head: got q_hit %b expected 1", q_hit);
        end
    endtask

    task automatic test_wrap();
        int xs[4];
        int ex, idx;
        bit ed;
        xs = '{5, 6, 7, 0};
        move_direction = 2'd2;
        do_reset();
        for (int k = 1; k <= 4 * SD; k++) begin
            cycle();
            n_checks++;
            if (step_pulse !== ((k % SD) == 0)) begin
                n_fail++;
                $display("[TB] FAIL wrap_pulse k=%0d: got %b expected %b", k, step_pulse, (k % SD) == 0);
            end
            if ((k % SD) == 0) begin
                idx = k / SD - 1;
                ed  = WALL_KILL && idx == 3;
                ex  = ed ? 7 : xs[idx];
                n_checks++;
                if ({head_x, head_y, length, dead} !== {3'(ex), 3'd4, 4'd3, ed}) begin
                    n_fail++;
                    $display("[TB] FAIL wrap_head k=%0d: got (%0d,%0d) len %0d dead %b expected (%0d,4) len 3 dead %b",
                             k, head_x, head_y, length, dead, ex, ed);
                end
            end
        end
    endtask

    task automatic test_reversal();
        move_direction = 2'd0;
        do_reset();
        repeat (SD) cycle();
        n_checks++;
        if ({head_x, head_y, heading} !== {3'd5, 3'd4, 2'd2}) begin
            n_fail++;
            $display("[TB] FAIL reversal_reject: got (%0d,%0d) hd %0d expected (5,4) hd 2", head_x, head_y, heading);
        end
        move_direction = 2'd1;
        repeat (SD) cycle();
        n_checks++;
        if ({head_x, head_y, heading} !== {3'd5, 3'd3, 2'd1}) begin
            n_fail++;
            $display("[TB] FAIL turn_up: got (%0d,%0d) hd %0d expected (5,3) hd 1", head_x, head_y, heading);
        end
        repeat (SD) cycle();
        n_checks++;
        if ({head_x, head_y} !== {3'd5, 3'd2}) begin
            n_fail++;
            $display("[TB] FAIL keep_up: got (%0d,%0d) expected (5,2)", head_x, head_y);
        end
    endtask

    task automatic test_grow();
        move_direction = 2'd2;
        do_reset();
        grow = 1'b1;
        cycle();
        grow = 1'b0;
        repeat (SD - 1) cycle();
        n_checks++;
        if ({head_x, length} !== {3'd5, 4'd4}) begin
            n_fail++;
            $display("[TB] FAIL grow_first: got x %0d len %0d expected x 5 len 4", head_x, length);
        end
        grow = 1'b1;
        cycle();
        grow = 1'b0;
        repeat (SD - 1) cycle();
        n_checks++;
        if ({head_x, length} !== {3'd6, 4'd5}) begin
            n_fail++;
            $display("[TB] FAIL grow_second: got x %0d len %0d expected x 6 len 5", head_x, length);
        end
        qx = 3'd4;
        qy = 3'd4;
        cycle();
        n_checks++;
        if (q_hit !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL query_body: got %b expected 1", q_hit);
        end
        qx = 3'd2;
        cycle();
        n_checks++;
        if (q_hit !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL query_tail: got %b expected 1", q_hit);
        end
        qx = 3'd1;
        qy = 3'd6;
        cycle();
        n_checks++;
        if (q_hit !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL query_empty: got %b expected 0", q_hit);
        end
        n_checks++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("[TB] FAIL grow_model: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_max_len();
        int dirs[8];
        dirs = '{1, 1, 1, 2, 2, 2, 3, 3};
        do_reset();
        grow = 1'b1;
        for (int s = 0; s < 8; s++) begin
            move_direction = 2'(dirs[s]);
            repeat (SD) cycle();
        end
        grow = 1'b0;
        n_checks++;
        if ({head_x, head_y, length, dead} !== {3'd7, 3'd3, 4'd8, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL max_len: got (%0d,%0d) len %0d dead %b expected (7,3) len 8 dead 0",
                     head_x, head_y, length, dead);
        end
    endtask

    task automatic test_collision();
        move_direction = 2'd2;
        do_reset();
        for (int s = 0; s < 2; s++) begin
            grow = 1'b1;
            cycle();
            grow = 1'b0;
            repeat (SD - 1) cycle();
        end
        move_direction = 2'd1;
        repeat (SD) cycle();
        move_direction = 2'd0;
        repeat (SD) cycle();
        move_direction = 2'd3;
        repeat (SD) cycle();
        n_checks++;
        if ({head_x, head_y, length, step_pulse, dead} !== {3'd5, 3'd3, 4'd5, 1'b1, 1'b1}) begin
            n_fail++;
            $display("[TB] FAIL collide: got (%0d,%0d) len %0d pulse %b dead %b expected (5,3) len 5 pulse 1 dead 1",
                     head_x, head_y, length, step_pulse, dead);
        end
        move_direction = 2'd0;
        for (int k = 0; k < 3 * SD; k++) begin
            cycle();
            n_checks++;
            if ({head_x, head_y, step_pulse, dead} !== {3'd5, 3'd3, 1'b0, 1'b1}) begin
                n_fail++;
                $display("[TB] FAIL dead_frozen k=%0d: got (%0d,%0d) pulse %b dead %b expected (5,3) pulse 0 dead 1",
                         k, head_x, head_y, step_pulse, dead);
            end
        end
        do_reset();
        n_checks++;
        if ({head_x, head_y, length, dead} !== {3'd4, 3'd4, 4'd3, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL dead_reset: got (%0d,%0d) len %0d dead %b expected (4,4) len 3 dead 0",
                     head_x, head_y, length, dead);
        end
    endtask

    task automatic test_pause();
        int waited;
        bit seen;
        move_direction = 2'd2;
        do_reset();
        repeat (2) cycle();
        pause = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cycle();
            n_checks++;
            if ({step_pulse, head_x, head_y} !== {1'b0, 3'd4, 3'd4}) begin
                n_fail++;
                $display("[TB] FAIL pause_hold k=%0d: got pulse %b (%0d,%0d) expected pulse 0 (4,4)",
                         k, step_pulse, head_x, head_y);
            end
        end
        pause  = 1'b0;
        waited = 0;
        seen   = 0;
        while (!seen && waited < 20) begin
            cycle();
            waited++;
            if (step_pulse === 1'b1) seen = 1;
        end
        n_checks++;
        if (!seen || waited != SD - 2 || head_x !== 3'd5) begin
            n_fail++;
            $display("[TB] FAIL pause_resume: got seen %b after %0d clocks x %0d expected step after %0d clocks x 5",
                     seen, waited, head_x, SD - 2);
        end
        repeat (SD - 1) cycle();
        pause = 1'b1;
        cycle();
        n_checks++;
        if ({step_pulse, head_x} !== {1'b0, 3'd5}) begin
            n_fail++;
            $display("[TB] FAIL pause_at_terminal: got pulse %b x %0d expected pulse 0 x 5", step_pulse, head_x);
        end
        pause = 1'b0;
        cycle();
        n_checks++;
        if ({step_pulse, head_x} !== {1'b1, 3'd6}) begin
            n_fail++;
            $display("[TB] FAIL pause_release_step: got pulse %b x %0d expected pulse 1 x 6", step_pulse, head_x);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 800; k++) begin
            reset          = ($urandom_range(0, 149) == 0);
            move_direction = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : move_direction;
            pause          = ($urandom_range(0, 9) == 0);
            grow           = ($urandom_range(0, 5) == 0);
            qx             = 3'($urandom_range(0, GW - 1));
            qy             = 3'($urandom_range(0, GH - 1));
            cycle();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("[TB] FAIL random_model k=%0d: got %h expected %h", k, obs_vec(), exp_vec());
            end
        end
        reset = 1'b0;
        pause = 1'b0;
        grow  = 1'b0;
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_reversal();
        test_grow();
        test_max_len();
        test_collision();
        test_pause();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
